// File: rtl/bridge_pkg.sv
// Shared definitions for the AHB-to-APB bridge: controller states, the
// peripheral address map and the one-hot select decode used by both halves.
package bridge_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WWAIT,
    ST_READ,
    ST_WRITE,
    ST_WRITEP,
    ST_RENABLE,
    ST_WENABLE,
    ST_WENABLEP
  } state_t;

  // Peripheral windows are [MAP_SLVn, MAP_SLVn+1); MAP_END closes the last one.
  localparam logic [31:0] MAP_SLV0 = 32'h8000_0000;
  localparam logic [31:0] MAP_SLV1 = 32'h8400_0000;
  localparam logic [31:0] MAP_SLV2 = 32'h8800_0000;
  localparam logic [31:0] MAP_END  = 32'h8C00_0000;

  localparam logic [2:0] SEL_NONE = 3'b000;
  localparam logic [2:0] SEL_SLV0 = 3'b001;
  localparam logic [2:0] SEL_SLV1 = 3'b010;
  localparam logic [2:0] SEL_SLV2 = 3'b100;

  function automatic logic [2:0] decode_sel(input logic [31:0] addr);
    logic [2:0] sel;
    sel = SEL_NONE;
    if (addr >= MAP_SLV0 && addr < MAP_SLV1)      sel = SEL_SLV0;
    else if (addr >= MAP_SLV1 && addr < MAP_SLV2) sel = SEL_SLV1;
    else if (addr >= MAP_SLV2 && addr < MAP_END)  sel = SEL_SLV2;
    return sel;
  endfunction

endpackage

// File: rtl/apb_controller.sv
// APB-side engine of the AHB-to-APB bridge: sequences SETUP/ACCESS phases from
// the front end's pipelined copies and stalls the AHB master via hready_out.
module apb_controller
  import bridge_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int NSEL   = 3
) (
  input  logic              hclk,
  input  logic              hresetn,
  input  logic              valid,
  input  logic              hwrite,
  input  logic              hwrite_reg,
  input  logic [ADDR_W-1:0] haddr,
  input  logic [ADDR_W-1:0] haddr1,
  input  logic [ADDR_W-1:0] haddr2,
  input  logic [DATA_W-1:0] hwdata,
  input  logic [DATA_W-1:0] hwdata1,
  output logic [NSEL-1:0]   pselx,
  output logic              penable,
  output logic              pwrite,
  output logic [ADDR_W-1:0] paddr,
  output logic [DATA_W-1:0] pwdata,
  output logic              hready_out
);

  state_t            state, next_state;
  logic [ADDR_W-1:0] setup_addr;
  logic [DATA_W-1:0] setup_data;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) state <= ST_IDLE;
    else          state <= next_state;
  end

  // NOTE: next_state is defaulted before the case so no path leaves it unassigned (no latch).
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE, ST_RENABLE, ST_WENABLE: begin
        if (valid && !hwrite)     next_state = ST_READ;
        else if (valid && hwrite) next_state = ST_WWAIT;
        else                      next_state = ST_IDLE;
      end
      ST_WWAIT:    next_state = valid ? ST_WRITEP : ST_WRITE;
      ST_READ:     next_state = ST_RENABLE;
      ST_WRITE:    next_state = valid ? ST_WENABLEP : ST_WENABLE;
      ST_WRITEP:   next_state = ST_WENABLEP;
      ST_WENABLEP: begin
        if (!hwrite_reg) next_state = ST_READ;
        else if (valid)  next_state = ST_WRITEP;
        else             next_state = ST_WRITE;
      end
      default:     next_state = ST_IDLE;
    endcase
  end

  // Leaving WENABLEP the next transfer is two address stages back and its data one
  // stage back; otherwise a read uses the live address and a write the one-cycle-old one.
  always_comb begin
    setup_addr = haddr;
    setup_data = hwdata;
    if (state == ST_WENABLEP) begin
      setup_addr = haddr2;
      setup_data = hwdata1;
    end else if (next_state != ST_READ) begin
      setup_addr = haddr1;
    end
  end

  always_ff @(posedge hclk or negedge hresetn) begin
    if (!hresetn) begin
      pselx      <= '0;
      penable    <= 1'b0;
      pwrite     <= 1'b0;
      paddr      <= '0;
      pwdata     <= '0;
      hready_out <= 1'b1;
    end else begin
      case (next_state)
        ST_IDLE, ST_WWAIT: begin
          pselx      <= '0;
          penable    <= 1'b0;
          hready_out <= 1'b1;
        end
        ST_READ: begin
          paddr      <= setup_addr;
          pselx      <= NSEL'(decode_sel(32'(setup_addr)));
          pwrite     <= 1'b0;
          penable    <= 1'b0;
          hready_out <= 1'b0;
        end
        ST_WRITE, ST_WRITEP: begin
          paddr      <= setup_addr;
          pwdata     <= setup_data;
          pselx      <= NSEL'(decode_sel(32'(setup_addr)));
          pwrite     <= 1'b1;
          penable    <= 1'b0;
          hready_out <= 1'b0;
        end
        default: begin
          // ACCESS phase: select, address, direction and data are held from SETUP.
          penable    <= 1'b1;
          hready_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_apb_controller.sv
// Self-checking bench for apb_controller: an AHB master/front-end model feeds the
// bridge, and a transfer-level scoreboard checks every APB access and the protocol.
module tb_apb_controller;

  logic        hclk = 1'b0;
  logic        hresetn;
  logic        valid, hwrite, hwrite_reg;
  logic [31:0] haddr, haddr1, haddr2, hwdata, hwdata1;
  logic [2:0]  pselx;
  logic        penable, pwrite, hready_out;
  logic [31:0] paddr, pwdata;

  apb_controller #(.ADDR_W(32), .DATA_W(32), .NSEL(3)) dut (
    .hclk(hclk), .hresetn(hresetn), .valid(valid), .hwrite(hwrite),
    .hwrite_reg(hwrite_reg), .haddr(haddr), .haddr1(haddr1), .haddr2(haddr2),
    .hwdata(hwdata), .hwdata1(hwdata1), .pselx(pselx), .penable(penable),
    .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata), .hready_out(hready_out)
  );

  always #5 hclk = ~hclk;

  typedef struct {
    logic [31:0] addr;
    logic        write;
    logic [31:0] data;
  } xfer_t;

  xfer_t pend_q[$];  // transfers the master has yet to present
  xfer_t exp_q[$];   // accepted AHB transfers awaiting their APB access
  xfer_t ap, dp;
  bit    ap_v, dp_v, rdy;
  int    cyc, tests, fails;
  logic  prev_penable, prev_setup;
  logic [2:0] prev_pselx;

  // Address map: three 64 MB windows starting at 0x8000_0000, anything else unselected.
  function automatic logic [2:0] model_sel(input logic [31:0] a);
    if (a < 32'h8000_0000 || a >= 32'h8C00_0000) return 3'b000;
    return 3'b001 << ((a - 32'h8000_0000) / 32'h0400_0000);
  endfunction

  task automatic push_xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
    xfer_t x;
    x.addr = a; x.write = w; x.data = d;
    pend_q.push_back(x);
  endtask

  task automatic clear_tb();
    pend_q.delete(); exp_q.delete();
    ap_v = 0; dp_v = 0; rdy = 1;
    valid = 0; hwrite = 0; haddr = '0; hwdata = '0;
    hwrite_reg = 0; haddr1 = '0; haddr2 = '0; hwdata1 = '0;
    prev_penable = 0; prev_setup = 0; prev_pselx = '0;
  endtask

  // One bus cycle: front-end copies shift, the master advances if the last cycle was
  // ready, then outputs are sampled at the falling edge and checked against the model.
  task automatic tick();
    xfer_t e;
    @(posedge hclk);
    #1;
    hwrite_reg = hwrite; haddr2 = haddr1; haddr1 = haddr; hwdata1 = hwdata;
    if (rdy) begin
      if (ap_v) begin exp_q.push_back(ap); dp = ap; dp_v = 1; end
      else dp_v = 0;
      if (pend_q.size() > 0) begin ap = pend_q.pop_front(); ap_v = 1; end
      else ap_v = 0;
    end
    valid = ap_v;
    if (ap_v) begin haddr = ap.addr; hwrite = ap.write; end
    if (dp_v && dp.write) hwdata = dp.data;
    @(negedge hclk);
    cyc++;
    rdy = hready_out;
    tests++;
    if (!$onehot0(pselx)) begin
      fails++; $display("FAIL pselx_onehot: cycle %0d pselx=%b", cyc, pselx);
    end
    if (prev_setup) begin
      tests++;
      if (penable !== 1'b1) begin
        fails++; $display("FAIL setup_without_access: cycle %0d penable=%b expected 1", cyc, penable);
      end
    end
    if (penable === 1'b1) begin
      tests++;
      if (prev_penable !== 1'b0 || pselx !== prev_pselx) begin
        fails++;
        $display("FAIL access_after_setup: cycle %0d pselx=%b prev=%b prev_penable=%b", cyc, pselx, prev_pselx, prev_penable);
      end
      tests++;
      if (exp_q.size() == 0) begin
        fails++; $display("FAIL unexpected_access: cycle %0d paddr=%h", cyc, paddr);
      end else begin
        e = exp_q.pop_front();
        if (pselx !== model_sel(e.addr) || paddr !== e.addr || pwrite !== e.write ||
            hready_out !== 1'b1 || (e.write && pwdata !== e.data)) begin
          fails++;
          $display("FAIL apb_access: cycle %0d got sel=%b addr=%h wr=%b data=%h rdy=%b expected sel=%b addr=%h wr=%b data=%h rdy=1",
                   cyc, pselx, paddr, pwrite, pwdata, hready_out, model_sel(e.addr), e.addr, e.write, e.data);
        end
      end
    end
    prev_setup   = (penable === 1'b0) && (hready_out === 1'b0);
    prev_penable = penable;
    prev_pselx   = pselx;
  endtask

  task automatic test_reset();
    hresetn = 1'b0;
    clear_tb();
    #7;
    tests++;
    if (pselx !== 3'b000 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 ||
        pwdata !== '0 || hready_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_values: sel=%b en=%b wr=%b addr=%h data=%h rdy=%b expected 000 0 0 0 0 1",
               pselx, penable, pwrite, paddr, pwdata, hready_out);
    end
    @(negedge hclk);
    hresetn = 1'b1;
    rdy = hready_out;
  endtask

  task automatic test_single_read();
    push_xfer(32'h8000_0010, 1'b0, '0);
    tick();
    tick();
    tests++;
    if (pselx !== 3'b001 || paddr !== 32'h8000_0010 || pwrite !== 1'b0 || penable !== 1'b0 || hready_out !== 1'b0) begin
      fails++;
      $display("FAIL read_setup: sel=%b addr=%h wr=%b en=%b rdy=%b expected 001 80000010 0 0 0", pselx, paddr, pwrite, penable, hready_out);
    end
    tick();
    tests++;
    if (penable !== 1'b1 || hready_out !== 1'b1 || pselx !== 3'b001) begin
      fails++; $display("FAIL read_access: en=%b rdy=%b sel=%b expected 1 1 001", penable, hready_out, pselx);
    end
    tick();
    tests++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1 || paddr !== 32'h8000_0010) begin
      fails++;
      $display("FAIL read_idle: sel=%b en=%b rdy=%b addr=%h expected 000 0 1 80000010", pselx, penable, hready_out, paddr);
    end
  endtask

  task automatic test_single_write();
    push_xfer(32'h8400_0020, 1'b1, 32'hDEAD_BEEF);
    tick();
    tick();
    tests++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      fails++; $display("FAIL write_wait: sel=%b en=%b rdy=%b expected 000 0 1", pselx, penable, hready_out);
    end
    tick();
    tests++;
    if (pselx !== 3'b010 || paddr !== 32'h8400_0020 || pwdata !== 32'hDEAD_BEEF || pwrite !== 1'b1 ||
        penable !== 1'b0 || hready_out !== 1'b0) begin
      fails++;
      $display("FAIL write_setup: sel=%b addr=%h data=%h wr=%b en=%b rdy=%b expected 010 84000020 deadbeef 1 0 0",
               pselx, paddr, pwdata, pwrite, penable, hready_out);
    end
    tick();
    tests++;
    if (penable !== 1'b1 || hready_out !== 1'b1 || pselx !== 3'b010) begin
      fails++; $display("FAIL write_access: en=%b rdy=%b sel=%b expected 1 1 010", penable, hready_out, pselx);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    int c0;
    int acc[$];
    for (int i = 0; i < 3; i++) push_xfer(32'h8800_0000 + 32'(4 * i), 1'b1, 32'(i + 1));
    tick();
    c0 = cyc;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (penable === 1'b1) acc.push_back(cyc - c0);
      if (pselx !== 3'b000) begin
        tests++;
        if (pselx !== 3'b100) begin
          fails++; $display("FAIL b2b_select: cycle %0d pselx=%b expected 100", cyc, pselx);
        end
      end
    end
    tests++;
    if (acc.size() != 3) begin
      fails++; $display("FAIL b2b_access_count: got %0d expected 3", acc.size());
    end else if (acc[0] != 3 || acc[1] != 5 || acc[2] != 7) begin
      fails++; $display("FAIL b2b_timing: access cycles %0d %0d %0d expected 3 5 7", acc[0], acc[1], acc[2]);
    end
  endtask

  task automatic test_write_then_read();
    int wr_acc, rd_setup;
    logic [31:0] rd_addr;
    logic [2:0]  rd_sel;
    wr_acc = -1; rd_setup = -1; rd_addr = '0; rd_sel = '0;
    push_xfer(32'h8000_0004, 1'b1, $urandom);
    push_xfer(32'h8400_0008, 1'b0, '0);
    tick();
    for (int i = 0; i < 10; i++) begin
      tick();
      if (penable === 1'b1 && pwrite === 1'b1 && wr_acc < 0) wr_acc = cyc;
      if (penable === 1'b0 && hready_out === 1'b0 && pwrite === 1'b0 && rd_setup < 0) begin
        rd_setup = cyc; rd_addr = paddr; rd_sel = pselx;
      end
    end
    tests++;
    if (wr_acc < 0 || rd_setup != wr_acc + 1 || rd_addr !== 32'h8400_0008 || rd_sel !== 3'b010) begin
      fails++;
      $display("FAIL write_then_read: wr_access=%0d rd_setup=%0d addr=%h sel=%b expected setup right after access, 84000008, 010",
               wr_acc, rd_setup, rd_addr, rd_sel);
    end
  endtask

  task automatic test_decode_boundaries();
    logic [31:0] addrs[5];
    logic [2:0]  sels[5];
    addrs = '{32'h83FF_FFFC, 32'h8400_0000, 32'h8BFF_FFFC, 32'h8C00_0000, 32'h7FFF_FFFC};
    sels  = '{3'b001, 3'b010, 3'b100, 3'b000, 3'b000};
    for (int i = 0; i < 5; i++) begin
      push_xfer(addrs[i], 1'b0, '0);
      tick();
      tick();
      tests++;
      if (pselx !== sels[i] || paddr !== addrs[i]) begin
        fails++; $display("FAIL decode_%0d: addr=%h sel=%b expected %h %b", i, paddr, pselx, addrs[i], sels[i]);
      end
      tick();
      tick();
    end
  endtask

  task automatic test_idle();
    for (int i = 0; i < 10; i++) begin
      tick();
      tests++;
      if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
        fails++; $display("FAIL idle_hold: cycle %0d sel=%b en=%b rdy=%b expected 000 0 1", cyc, pselx, penable, hready_out);
      end
    end
  endtask

  task automatic test_reset_mid_access();
    bit found;
    found = 0;
    push_xfer(32'h8800_0100, 1'b1, $urandom);
    for (int i = 0; i < 8 && !found; i++) begin
      tick();
      if (penable === 1'b1) found = 1;
    end
    tests++;
    if (!found) begin
      fails++; $display("FAIL reset_mid_reach_access: no ACCESS within 8 cycles");
    end
    #2;
    hresetn = 1'b0;
    #1;
    tests++;
    if (pselx !== 3'b000 || penable !== 1'b0 || pwrite !== 1'b0 || paddr !== '0 ||
        pwdata !== '0 || hready_out !== 1'b1) begin
      fails++;
      $display("FAIL reset_mid_access: sel=%b en=%b wr=%b addr=%h data=%h rdy=%b expected 000 0 0 0 0 1",
               pselx, penable, pwrite, paddr, pwdata, hready_out);
    end
    @(posedge hclk);
    #2;
    hresetn = 1'b1;
    clear_tb();
    @(negedge hclk);
    rdy = hready_out;
    tick();
    tests++;
    if (pselx !== 3'b000 || penable !== 1'b0 || hready_out !== 1'b1) begin
      fails++; $display("FAIL reset_mid_idle: sel=%b en=%b rdy=%b expected 000 0 1", pselx, penable, hready_out);
    end
  endtask

  task automatic test_random();
    int n;
    bit drained;
    logic [31:0] a;
    for (int g = 0; g < 25; g++) begin
      n = ($urandom_range(0, 2) == 0) ? 0 : int'($urandom_range(1, 4));
      if (n == 0) begin
        a = 32'h8000_0000 + 32'h0400_0000 * $urandom_range(0, 2) + ($urandom & 32'h03FF_FFFC);
        push_xfer(a, 1'b0, '0);
      end else begin
        for (int k = 0; k < n; k++) begin
          a = 32'h8000_0000 + 32'h0400_0000 * $urandom_range(0, 2) + ($urandom & 32'h03FF_FFFC);
          push_xfer(a, 1'b1, $urandom);
        end
      end
      drained = 0;
      for (int i = 0; i < 40 && !drained; i++) begin
        tick();
        drained = (pend_q.size() == 0) && !ap_v && (exp_q.size() == 0);
      end
      tests++;
      if (!drained) begin
        fails++; $display("FAIL random_drain: group %0d left %0d transfers outstanding", g, exp_q.size() + pend_q.size());
      end
      tick();
      tick();
    end
  endtask

  initial begin
    tests = 0; fails = 0; cyc = 0;
    test_reset();
    test_single_read();
    test_single_write();
    test_back_to_back();
    test_write_then_read();
    test_decode_boundaries();
    test_idle();
    test_reset_mid_access();
    test_random();
    tests++;
    if (exp_q.size() != 0) begin
      fails++; $display("FAIL scoreboard_empty: %0d transfers never reached APB", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
